// File: rtl/block_depth_checker.sv
// block_depth_checker: streaming begin/end nesting checker over an ASCII
// character stream. A word FSM recognises whole-word "begin"/"end" keywords
// and a registered datapath tracks nesting depth plus sticky error flags.
module block_depth_checker #(
  parameter int MAX_DEPTH = 15,
  parameter int DEPTH_W   = 4,
  parameter bit CASE_SENS = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow
);

  localparam logic [7:0] ChSep = 8'h20;
  localparam logic [7:0] ChB   = 8'h62;
  localparam logic [7:0] ChE   = 8'h65;
  localparam logic [7:0] ChG   = 8'h67;
  localparam logic [7:0] ChI   = 8'h69;
  localparam logic [7:0] ChN   = 8'h6e;
  localparam logic [7:0] ChD   = 8'h64;
  localparam logic [DEPTH_W-1:0] DepthMax = DEPTH_W'(MAX_DEPTH);

  typedef enum logic [3:0] {
    IDLE, B1, B2, B3, B4, B5, E1, E2, E3, SKIP
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               underflow_q, underflow_d;
  logic               overflow_q, overflow_d;
  logic               result_q, result_d;

  logic [7:0] ch;
  logic       isSep;
  logic       isBegin;
  logic       isEnd;

  // Letter normalisation: fold upper case to lower unless matching is case sensitive
  always_comb begin
    ch = in;
    if (!CASE_SENS && (in >= 8'h41) && (in <= 8'h5a)) begin
      ch = in + 8'h20;
    end
  end

  assign isSep = (in == ChSep);

  // State register for the word-recognition FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk keyword prefixes, fall into SKIP on any mismatch
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      if (isSep) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    state_d = (ch == ChB) ? B1 : (ch == ChE) ? E1 : SKIP;
          B1:      state_d = (ch == ChE) ? B2 : SKIP;
          B2:      state_d = (ch == ChG) ? B3 : SKIP;
          B3:      state_d = (ch == ChI) ? B4 : SKIP;
          B4:      state_d = (ch == ChN) ? B5 : SKIP;
          E1:      state_d = (ch == ChN) ? E2 : SKIP;
          E2:      state_d = (ch == ChD) ? E3 : SKIP;
          default: state_d = SKIP;
        endcase
      end
    end
  end

  // Output logic: classify a completed keyword on its separator and update depth/flags
  always_comb begin
    isBegin     = in_valid && isSep && (state_q == B5);
    isEnd       = in_valid && isSep && (state_q == E3);
    depth_d     = depth_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (!(underflow_q || overflow_q)) begin
      if (isBegin) begin
        if (depth_q == DepthMax) begin
          overflow_d = 1'b1;
        end else begin
          depth_d = depth_q + 1'b1;
        end
      end else if (isEnd) begin
        if (depth_q == '0) begin
          underflow_d = 1'b1;
        end else begin
          depth_d = depth_q - 1'b1;
        end
      end
    end
    result_d = (depth_d == '0) && !underflow_d && !overflow_d;
  end

  // Registered datapath so every output is free of combinational paths from the input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      result_q    <= 1'b1;
    end else begin
      depth_q     <= depth_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      result_q    <= result_d;
    end
  end

  assign depth     = depth_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;
  assign result    = result_q;

endmodule

// File: tb/tb_block_depth_checker.sv
// tb_block_depth_checker: drives one character stream into three configurations
// (default, shallow MAX_DEPTH=2, case sensitive) and compares each against a
// word-level reference model that buffers whole words and compares strings.
module tb_block_depth_checker;

  logic       clk;
  logic       resetN;
  logic       inValid;
  logic [7:0] inChar;

  logic       resultA, underflowA, overflowA;
  logic [3:0] depthA;
  logic       resultB, underflowB, overflowB;
  logic [1:0] depthB;
  logic       resultC, underflowC, overflowC;
  logic [3:0] depthC;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance
  int  mMax[3]  = '{15, 2, 15};
  bit  mCase[3] = '{1'b0, 1'b0, 1'b1};
  int  mDepth[3];
  bit  mUf[3];
  bit  mOf[3];
  byte wordQ[$];

  block_depth_checker #(.MAX_DEPTH(15), .DEPTH_W(4), .CASE_SENS(1'b0)) dutA (
    .clk(clk), .reset(resetN), .in_valid(inValid), .in(inChar),
    .result(resultA), .depth(depthA), .underflow(underflowA), .overflow(overflowA)
  );

  block_depth_checker #(.MAX_DEPTH(2), .DEPTH_W(2), .CASE_SENS(1'b0)) dutB (
    .clk(clk), .reset(resetN), .in_valid(inValid), .in(inChar),
    .result(resultB), .depth(depthB), .underflow(underflowB), .overflow(overflowB)
  );

  block_depth_checker #(.MAX_DEPTH(15), .DEPTH_W(4), .CASE_SENS(1'b1)) dutC (
    .clk(clk), .reset(resetN), .in_valid(inValid), .in(inChar),
    .result(resultC), .depth(depthC), .underflow(underflowC), .overflow(overflowC)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Does the buffered word spell the keyword, honouring the case mode?
  function automatic bit wordIs(string kw, bit caseSens);
    byte c;
    if (wordQ.size() != kw.len()) return 1'b0;
    foreach (wordQ[i]) begin
      c = wordQ[i];
      if (!caseSens && c >= "A" && c <= "Z") c = c + 8'd32;
      if (c != kw[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Clear model to its power-on state
  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mDepth[k] = 0;
      mUf[k]    = 1'b0;
      mOf[k]    = 1'b0;
    end
    wordQ.delete();
  endtask

  // Feed one accepted character to the model
  task automatic modelChar(byte c);
    bit isB;
    bit isE;
    if (c == 8'h20) begin
      for (int k = 0; k < 3; k++) begin
        isB = wordIs("begin", mCase[k]);
        isE = wordIs("end", mCase[k]);
        if (!mUf[k] && !mOf[k]) begin
          if (isB) begin
            if (mDepth[k] == mMax[k]) mOf[k] = 1'b1;
            else mDepth[k]++;
          end else if (isE) begin
            if (mDepth[k] == 0) mUf[k] = 1'b1;
            else mDepth[k]--;
          end
        end
      end
      wordQ.delete();
    end else begin
      wordQ.push_back(c);
    end
  endtask

  task automatic checkOne(string tag, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(string step);
    int expRes[3];
    for (int k = 0; k < 3; k++) expRes[k] = (mDepth[k] == 0 && !mUf[k] && !mOf[k]) ? 1 : 0;
    checkOne({step, " A.depth"},     int'(depthA),     mDepth[0]);
    checkOne({step, " A.result"},    int'(resultA),    expRes[0]);
    checkOne({step, " A.underflow"}, int'(underflowA), int'(mUf[0]));
    checkOne({step, " A.overflow"},  int'(overflowA),  int'(mOf[0]));
    checkOne({step, " B.depth"},     int'(depthB),     mDepth[1]);
    checkOne({step, " B.result"},    int'(resultB),    expRes[1]);
    checkOne({step, " B.underflow"}, int'(underflowB), int'(mUf[1]));
    checkOne({step, " B.overflow"},  int'(overflowB),  int'(mOf[1]));
    checkOne({step, " C.depth"},     int'(depthC),     mDepth[2]);
    checkOne({step, " C.result"},    int'(resultC),    expRes[2]);
    checkOne({step, " C.underflow"}, int'(underflowC), int'(mUf[2]));
    checkOne({step, " C.overflow"},  int'(overflowC),  int'(mOf[2]));
  endtask

  // One clock cycle: drive on the falling edge, update model at the rising edge, check just after
  task automatic applyStimulus(string step, byte c, bit v);
    @(negedge clk);
    inChar  = c;
    inValid = v;
    @(posedge clk);
    if (v) modelChar(c);
    #1;
    checkOutput(step);
  endtask

  // Send a string, optionally with random idle cycles carrying junk data
  task automatic sendStr(string step, string s, bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) applyStimulus(step, 8'h20, 1'b0);
      applyStimulus(step, s[i], 1'b1);
    end
    inValid = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic doReset(string step);
    @(negedge clk);
    inValid = 1'b0;
    #2 resetN = 1'b0;
    modelReset();
    #1;
    checkOutput(step);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    byte alpha[12] = '{"b", "e", "g", "i", "n", "d", "B", "E", "N", "x", " ", " "};
    resetN  = 1'b1;
    inValid = 1'b0;
    inChar  = 8'h00;
    modelReset();

    doReset("reset");
    sendStr("mixed-case", "a BEgIn enD ", 1'b0);
    sendStr("nested", "begin begin end ", 1'b0);
    sendStr("close", "end ", 1'b0);

    doReset("reset2");
    sendStr("underflow", "end begin end ", 1'b0);

    doReset("reset3");
    sendStr("overflow", "begin begin begin end end ", 1'b0);

    doReset("reset4");
    sendStr("non-keywords", "beginx endd  en bend ", 1'b1);
    sendStr("upper", "BEGIN ", 1'b0);
    sendStr("upper-close", "end ", 1'b0);
    sendStr("trailing", "begin", 1'b0);
    applyStimulus("idle-sep", 8'h20, 1'b0);
    applyStimulus("late-sep", 8'h20, 1'b1);

    doReset("reset5");
    sendStr("pre-reset", "begin beg", 1'b0);
    doReset("mid-word-reset");
    sendStr("post-reset", "end ", 1'b0);

    doReset("reset6");
    for (int i = 0; i < 16; i++) sendStr("deep", "begin ", 1'b0);
    sendStr("deep-end", "end ", 1'b0);

    for (int r = 0; r < 5; r++) begin
      doReset("rand-reset");
      for (int i = 0; i < 300; i++) begin
        applyStimulus("random", alpha[$urandom_range(0, 11)], ($urandom_range(0, 4) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
